// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered RV32/RV64 execute stage (ALU, branch/jump resolve, optional iterative multiply)
// Build option: define EXE_MUL_EN to build the iterative multiplier and its MUL/DONE states.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid / o_ready        upstream handshake; i_flush kills accepted/in-flight work
//   i_alu_*_sel, i_funct3    ALU operand/op select, branch condition or multiply variant
//   i_branch_sel, i_jump_sel, i_jump_type_sel, i_mul_sel  control-flow and multiply select
//   i_rs1, i_rs2, i_immed, i_pc, i_rd                     operands, immediate, pc, destination
//   o_valid / i_ready        downstream handshake
//   o_result, o_pc_immed, o_jump_addr, o_branch_taken, o_rd  registered results
module exe_stage_pipe #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic            i_alu_input_sel,
    input  logic [2:0]      i_alu_op_sel,
    input  logic            i_alu_sub_sel,
    input  logic            i_alu_arith_sel,
    input  logic            i_branch_sel,
    input  logic            i_jump_sel,
    input  logic            i_jump_type_sel,
    input  logic            i_mul_sel,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_immed,
    input  logic [XLEN-1:0] i_pc,
    input  logic [RD_W-1:0] i_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_pc_immed,
    output logic [XLEN-1:0] o_jump_addr,
    output logic            o_branch_taken,
    output logic [RD_W-1:0] o_rd
);
    localparam int SHW = $clog2(XLEN);
    logic            w_accept, w_alu_load, w_done_load, w_cond;
    logic [XLEN-1:0] w_op2, w_alu, w_sra, w_pc_immed, w_tgt, w_mres;
    logic [SHW-1:0]  w_shamt;
    logic [RD_W-1:0] w_mrd;
    logic            r_valid, r_taken;
    logic [XLEN-1:0] r_result, r_pc_immed, r_jump_addr;
    logic [RD_W-1:0] r_rd;
    assign w_accept   = i_valid & o_ready & ~i_flush;
    assign w_op2      = i_alu_input_sel ? i_immed : i_rs2;
    assign w_shamt    = w_op2[SHW-1:0];
    assign w_sra      = $signed(i_rs1) >>> w_shamt;
    assign w_pc_immed = i_pc + i_immed;
    assign w_tgt      = (i_jump_type_sel ? i_rs1 + i_immed : w_pc_immed) & ~XLEN'(1);
    always_comb begin
        w_alu = '0;
        case (i_alu_op_sel)
            3'b000:  w_alu = i_alu_sub_sel ? i_rs1 - w_op2 : i_rs1 + w_op2;
            3'b001:  w_alu = i_rs1 << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(w_op2)};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, i_rs1 < w_op2};
            3'b100:  w_alu = i_rs1 ^ w_op2;
            3'b101:  w_alu = i_alu_arith_sel ? w_sra : i_rs1 >> w_shamt;
            3'b110:  w_alu = i_rs1 | w_op2;
            default: w_alu = i_rs1 & w_op2;
        endcase
    end
    // Branch compares always use rs2, never the immediate
    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            3'b000:  w_cond = i_rs1 == i_rs2;
            3'b001:  w_cond = i_rs1 != i_rs2;
            3'b100:  w_cond = $signed(i_rs1) < $signed(i_rs2);
            3'b101:  w_cond = $signed(i_rs1) >= $signed(i_rs2);
            3'b110:  w_cond = i_rs1 < i_rs2;
            3'b111:  w_cond = i_rs1 >= i_rs2;
            default: w_cond = 1'b0;
        endcase
    end
`ifdef EXE_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2;
    logic [1:0]        r_state;
    logic [2*XLEN-1:0] r_acc, r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [SHW-1:0]    r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [RD_W-1:0]   r_mrd;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [2*XLEN-1:0] w_prod;
    // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH
    assign w_a_neg     = (i_funct3[1:0] != 2'b11) & i_rs1[XLEN-1];
    assign w_b_neg     = ~i_funct3[1] & i_rs2[XLEN-1];
    assign w_a_mag     = w_a_neg ? -i_rs1 : i_rs1;
    assign w_b_mag     = w_b_neg ? -i_rs2 : i_rs2;
    assign w_prod      = r_neg ? -r_acc : r_acc;
    assign w_mres      = r_f3[2] ? '0 : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    assign w_mrd       = r_mrd;
    assign o_ready     = (r_state == S_IDLE) & (~r_valid | i_ready);
    assign w_alu_load  = w_accept & ~i_mul_sel;
    assign w_done_load = (r_state == S_DONE) & (~r_valid | i_ready) & ~i_flush;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_mrd    <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept & i_mul_sel) begin
                    r_state  <= S_MUL;
                    r_acc    <= '0;
                    r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                    r_mplier <= w_b_mag;
                    r_cnt    <= '0;
                    r_f3     <= i_funct3;
                    r_neg    <= w_a_neg ^ w_b_neg;
                    r_mrd    <= i_rd;
                end
                S_MUL: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    r_state  <= (r_cnt == SHW'(XLEN - 1)) ? S_DONE : S_MUL;
                end
                S_DONE: r_state <= (~r_valid | i_ready) ? S_IDLE : S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic w_unused;
    assign w_unused    = i_mul_sel;
    assign o_ready     = ~r_valid | i_ready;
    assign w_alu_load  = w_accept;
    assign w_done_load = 1'b0;
    assign w_mres      = '0;
    assign w_mrd       = '0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_taken     <= 1'b0;
            r_result    <= '0;
            r_pc_immed  <= '0;
            r_jump_addr <= '0;
            r_rd        <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_taken <= 1'b0;
        end else if (w_alu_load) begin
            r_valid     <= 1'b1;
            r_taken     <= i_jump_sel | (i_branch_sel & w_cond);
            r_result    <= i_jump_sel ? i_pc + XLEN'(4) : w_alu;
            r_pc_immed  <= w_pc_immed;
            r_jump_addr <= w_tgt;
            r_rd        <= i_rd;
        end else if (w_done_load) begin
            r_valid     <= 1'b1;
            r_taken     <= 1'b0;
            r_result    <= w_mres;
            r_pc_immed  <= '0;
            r_jump_addr <= '0;
            r_rd        <= w_mrd;
        end else if (i_ready) begin
            // taken is dropped with valid so a consumed redirect is never seen twice
            r_valid <= 1'b0;
            r_taken <= 1'b0;
        end
    end
    assign o_valid        = r_valid;
    assign o_branch_taken = r_taken;
    assign o_result       = r_result;
    assign o_pc_immed     = r_pc_immed;
    assign o_jump_addr    = r_jump_addr;
    assign o_rd           = r_rd;
endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: scoreboard bench for exe_stage_pipe with random stimulus and directed cases
module tb_exe_stage_pipe;
    localparam int XLEN = 32;
    localparam int RD_W = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic i_valid = 0, i_flush = 0, i_alu_input_sel = 0, i_alu_sub_sel = 0, i_alu_arith_sel = 0;
    logic i_branch_sel = 0, i_jump_sel = 0, i_jump_type_sel = 0, i_mul_sel = 0, i_ready = 1;
    logic [2:0] i_alu_op_sel = 0, i_funct3 = 0;
    logic [XLEN-1:0] i_rs1 = 0, i_rs2 = 0, i_immed = 0, i_pc = 0;
    logic [RD_W-1:0] i_rd = 0;
    logic o_ready, o_valid, o_branch_taken;
    logic [XLEN-1:0] o_result, o_pc_immed, o_jump_addr;
    logic [RD_W-1:0] o_rd;

    exe_stage_pipe #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_alu_input_sel(i_alu_input_sel), .i_alu_op_sel(i_alu_op_sel), .i_alu_sub_sel(i_alu_sub_sel),
        .i_alu_arith_sel(i_alu_arith_sel), .i_branch_sel(i_branch_sel), .i_jump_sel(i_jump_sel),
        .i_jump_type_sel(i_jump_type_sel), .i_mul_sel(i_mul_sel), .i_funct3(i_funct3),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_immed(i_immed), .i_pc(i_pc), .i_rd(i_rd),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_pc_immed(o_pc_immed),
        .o_jump_addr(o_jump_addr), .o_branch_taken(o_branch_taken), .o_rd(o_rd)
    );

    typedef struct {
        logic asel; logic [2:0] aop; logic sub, arith, br, jmp, jt, mul;
        logic [2:0] f3; logic [31:0] rs1, rs2, imm, pc; logic [4:0] rd;
    } op_t;
    typedef struct {logic [31:0] res, pci, ja; logic tk; logic [4:0] rd; bit full;} exp_t;

    exp_t sb[$];
    op_t  cur;
    int   passed = 0, total = 0;
    int   rdy_ctl = 1;
    int   wd = 0;
    exp_t me;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: straight from the ISA rules, with wide arithmetic for multiplies
    function automatic exp_t model(op_t o);
        exp_t e;
        logic [31:0] b;
        int sh;
        bit cond;
        logic signed [65:0] sa, sb2, p;
        e.full = 1; e.rd = o.rd; e.tk = 0; e.res = 0;
        b  = o.asel ? o.imm : o.rs2;
        sh = int'(b[4:0]);
`ifdef EXE_MUL_EN
        if (o.mul) begin
            if (o.f3[1:0] != 2'b11) sa = $signed(o.rs1); else sa = $signed({1'b0, o.rs1});
            if (!o.f3[1]) sb2 = $signed(o.rs2); else sb2 = $signed({1'b0, o.rs2});
            p = sa * sb2;
            e.res = o.f3[2] ? 32'd0 : (o.f3[1:0] == 2'b00 ? p[31:0] : p[63:32]);
            e.full = 0; e.pci = 0; e.ja = 0;
            return e;
        end
`endif
        case (o.aop)
            3'd0: e.res = o.sub ? o.rs1 - b : o.rs1 + b;
            3'd1: e.res = o.rs1 << sh;
            3'd2: e.res = ($signed(o.rs1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: e.res = (o.rs1 < b) ? 32'd1 : 32'd0;
            3'd4: e.res = o.rs1 ^ b;
            3'd5: if (o.arith) e.res = $signed(o.rs1) >>> sh; else e.res = o.rs1 >> sh;
            3'd6: e.res = o.rs1 | b;
            default: e.res = o.rs1 & b;
        endcase
        case (o.f3)
            3'd0: cond = o.rs1 == o.rs2;
            3'd1: cond = o.rs1 != o.rs2;
            3'd4: cond = $signed(o.rs1) < $signed(o.rs2);
            3'd5: cond = $signed(o.rs1) >= $signed(o.rs2);
            3'd6: cond = o.rs1 < o.rs2;
            3'd7: cond = o.rs1 >= o.rs2;
            default: cond = 0;
        endcase
        e.tk  = o.jmp | (o.br & cond);
        e.pci = o.pc + o.imm;
        e.ja  = (o.jt ? o.rs1 + o.imm : o.pc + o.imm) & 32'hFFFF_FFFE;
        if (o.jmp) e.res = o.pc + 32'd4;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 7));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.asel = 1'($urandom); o.aop = 3'($urandom); o.sub = 1'($urandom); o.arith = 1'($urandom);
        o.br = ($urandom_range(0, 3) == 0); o.jmp = ($urandom_range(0, 5) == 0); o.jt = 1'($urandom);
        o.mul = ($urandom_range(0, 4) == 0); o.f3 = 3'($urandom);
        o.rs1 = pick(); o.rs2 = pick(); o.imm = pick(); o.pc = $urandom; o.rd = 5'($urandom);
        return o;
    endfunction

    function automatic op_t nop();
        op_t o = '{default: '0};
        return o;
    endfunction

    task automatic drive(op_t o, logic v, logic fl);
        cur = o; i_valid = v; i_flush = fl;
        i_alu_input_sel = o.asel; i_alu_op_sel = o.aop; i_alu_sub_sel = o.sub; i_alu_arith_sel = o.arith;
        i_branch_sel = o.br; i_jump_sel = o.jmp; i_jump_type_sel = o.jt; i_mul_sel = o.mul;
        i_funct3 = o.f3; i_rs1 = o.rs1; i_rs2 = o.rs2; i_immed = o.imm; i_pc = o.pc; i_rd = o.rd;
    endtask

    // One clock: decide acceptance just before the edge, update the scoreboard just after it
    task automatic step(output bit acc);
        bit fl;
        #4;
        acc = i_valid && o_ready && !i_flush;
        fl  = i_flush;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        if (acc) sb.push_back(model(cur));
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bit a;
        i_valid = 0; i_flush = 0;
        repeat (n) step(a);
    endtask

    task automatic issue(op_t o, output int n);
        bit acc = 0;
        n = 0;
        drive(o, 1, 0);
        while (!acc && n < 100) begin step(acc); n++; end
        if (!acc) chk("issue_timeout", 0, 1);
        i_valid = 0;
    endtask

    // Monitor: pops the scoreboard on every output handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            i_ready = (rdy_ctl == 2) ? ($urandom_range(0, 3) != 0) : rdy_ctl[0];
            #3;
            if (o_valid && i_ready) begin
                wd = 0;
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    me = sb.pop_front();
                    chk("result", o_result, me.res);
                    chk("rd", o_rd, me.rd);
                    if (me.full) begin
                        chk("pc_immed", o_pc_immed, me.pci);
                        chk("jump_addr", o_jump_addr, me.ja);
                        chk("taken", o_branch_taken, me.tk);
                    end
                end
            end else if (sb.size() != 0) begin
                wd++;
                if (wd == 300) chk("sb_timeout", sb.size(), 0);
            end else wd = 0;
        end
    end

    initial begin
        op_t o, o2;
        exp_t ea;
        int n, bad;
        bit a;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_taken", o_branch_taken, 0);
        chk("rst_result", o_result, 0);
        chk("rst_pc_immed", o_pc_immed, 0);
        chk("rst_jump_addr", o_jump_addr, 0);
        chk("rst_rd", o_rd, 0);
        rst_n = 1;
        #1 chk("rst_ready", o_ready, 1);
        @(negedge clk);
        // add 5 + (-3)
        o = nop(); o.asel = 1; o.rs1 = 5; o.imm = -32'sd3; o.rd = 7;
        issue(o, n);
        chk("add_valid", o_valid, 1);
        chk("add_result", o_result, 2);
        idle(2);
        // stall: hold a result with i_ready low, then accept a new op on release
        rdy_ctl = 0;
        o = nop(); o.aop = 3'd4; o.rs1 = 32'hF0F0_1234; o.rs2 = 32'h0FF0_FFFF; o.rd = 3;
        ea = model(o);
        issue(o, n);
        for (int k = 0; k < 3; k++) begin
            chk("stall_ready", o_ready, 0);
            chk("stall_valid", o_valid, 1);
            chk("stall_result", o_result, ea.res);
            idle(1);
        end
        rdy_ctl = 1;
        o2 = nop(); o2.aop = 3'd1; o2.asel = 1; o2.rs1 = 32'h3; o2.imm = 32'd4; o2.rd = 9;
        issue(o2, n);
        chk("stall_release_accept_cycles", n, 1);
        chk("stall_next_result", o_result, 32'h30);
        idle(2);
        // bge / bgeu with rs1=-1, rs2=1
        o = nop(); o.br = 1; o.f3 = 3'b101; o.rs1 = 32'hFFFF_FFFF; o.rs2 = 1; o.asel = 1; o.imm = 32'h40; o.pc = 32'h100;
        issue(o, n);
        chk("bge_taken", o_branch_taken, 0);
        o.f3 = 3'b111;
        issue(o, n);
        chk("bgeu_taken", o_branch_taken, 1);
        chk("bgeu_addr", o_jump_addr, 32'h140);
        // jalr
        o = nop(); o.jmp = 1; o.jt = 1; o.rs1 = 32'h1001; o.imm = 4; o.pc = 32'h200;
        issue(o, n);
        chk("jalr_addr", o_jump_addr, 32'h1004);
        chk("jalr_result", o_result, 32'h204);
        chk("jalr_taken", o_branch_taken, 1);
        idle(2);
        // flush of a held result, with a concurrent op that must be dropped
        rdy_ctl = 0;
        o = nop(); o.jmp = 1; o.pc = 32'h80;
        issue(o, n);
        chk("hold_valid", o_valid, 1);
        o2 = nop(); o2.rs1 = 32'h11;
        drive(o2, 1, 1);
        step(a);
        i_valid = 0; i_flush = 0;
        chk("flush_valid", o_valid, 0);
        chk("flush_taken", o_branch_taken, 0);
        chk("flush_ready", o_ready, 1);
        idle(2);
        chk("flush_drop", o_valid, 0);
        rdy_ctl = 1;
`ifdef EXE_MUL_EN
        // MULH -2 * 3 -> all ones, busy for the whole iteration
        o = nop(); o.mul = 1; o.f3 = 3'b001; o.rs1 = 32'hFFFF_FFFE; o.rs2 = 3; o.rd = 4;
        issue(o, n);
        bad = 0; n = 0;
        while (!o_valid && n < 60) begin
            if (o_ready) bad++;
            idle(1);
            n++;
        end
        chk("mul_busy_ready", bad, 0);
        chk("mul_latency", n, 33);
        chk("mulh_result", o_result, 32'hFFFF_FFFF);
        o.f3 = 3'b011; o.rs1 = 32'hFFFF_FFFF; o.rs2 = 32'hFFFF_FFFF;
        issue(o, n);
        n = 0;
        while (!o_valid && n < 60) begin idle(1); n++; end
        chk("mulhu_result", o_result, 32'hFFFF_FFFE);
        idle(2);
        // flush in the tenth multiply cycle
        issue(o, n);
        idle(9);
        drive(nop(), 1, 1);
        step(a);
        i_valid = 0; i_flush = 0;
        chk("mulflush_valid", o_valid, 0);
        chk("mulflush_ready", o_ready, 1);
        idle(40);
        chk("mulflush_no_result", o_valid, 0);
        o = nop(); o.rs1 = 32'd10; o.rs2 = 32'd20;
        issue(o, n);
        chk("post_flush_add", o_result, 30);
        idle(2);
        // reset in the middle of a multiply
        o = nop(); o.mul = 1; o.rs1 = 7; o.rs2 = 9;
        issue(o, n);
        idle(5);
        rst_n = 0;
        sb.delete();
        #1 chk("midrst_result", o_result, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("midrst_ready", o_ready, 1);
        @(negedge clk);
        idle(40);
        chk("midrst_no_result", o_valid, 0);
`endif
        // random traffic with random backpressure and occasional flushes
        rdy_ctl = 2;
        repeat (1500) begin
            drive(rnd_op(), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
            step(a);
        end
        i_valid = 0; i_flush = 0;
        rdy_ctl = 1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin idle(1); n++; end
        chk("drain", sb.size(), 0);
        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
